// File: rtl/assert_report_arbiter.sv
// assert_report_arbiter
// Gathers assertion-failure pulses from NUM_SRC checker instances, counts them
// per source, parks at most one pending report per source and serialises the
// pending reports round-robin onto a single valid/ready report channel.
// Optional build macro ASSERT_RPT_TIMESTAMP_EN adds a free-running cycle
// counter whose value at failure time travels with each report (rpt_time_o).
module assert_report_arbiter #(
    parameter int NUM_SRC     = 4,
    parameter int ID_W        = 8,
    parameter int CNT_W       = 8,
    parameter int MAX_REPORTS = 4
`ifdef ASSERT_RPT_TIMESTAMP_EN
    ,
    parameter int TS_W        = 32
`endif
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_SRC-1:0]         fail_i,
    input  logic [NUM_SRC*ID_W-1:0]    fail_id_i,
    input  logic [NUM_SRC-1:0]         src_en_i,
    input  logic                       clr_i,
    output logic                       rpt_valid_o,
    input  logic                       rpt_ready_i,
    output logic [$clog2(NUM_SRC)-1:0] rpt_src_o,
    output logic [ID_W-1:0]            rpt_id_o,
    output logic [CNT_W-1:0]           rpt_seq_o,
`ifdef ASSERT_RPT_TIMESTAMP_EN
    output logic [TS_W-1:0]            rpt_time_o,
`endif
    output logic [NUM_SRC*CNT_W-1:0]   fail_cnt_o,
    output logic [CNT_W-1:0]           sup_cnt_o,
    output logic [CNT_W-1:0]           ovf_cnt_o,
    output logic                       any_fail_o
);

    localparam int SRC_W = $clog2(NUM_SRC);
    // Extra headroom so a multi-source increment can be saturated after the add
    localparam int SUM_W = CNT_W + 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MAX_RPT = CNT_W'(MAX_REPORTS);

    typedef enum logic {
        ST_IDLE,
        ST_PRESENT
    } state_t;

    // Per-source counters and pending slots
    logic [CNT_W-1:0] fail_cnt_q [NUM_SRC];
    logic             slot_full_q [NUM_SRC];
    logic [ID_W-1:0]  slot_id_q [NUM_SRC];
    logic [CNT_W-1:0] slot_seq_q [NUM_SRC];

    // Global counters
    logic [CNT_W-1:0] sup_cnt_q, sup_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             any_fail_q, any_fail_d;

    // Report channel / arbiter state
    state_t           state_q;
    logic             valid_q;
    logic [SRC_W-1:0] rpt_src_q;
    logic [ID_W-1:0]  rpt_id_q;
    logic [CNT_W-1:0] rpt_seq_q;
    logic [SRC_W-1:0] ptr_q, ptr_d;

    // Per-source event decode
    logic [NUM_SRC-1:0] accept;
    logic [NUM_SRC-1:0] to_slot;
    logic [NUM_SRC-1:0] sup_evt;
    logic [NUM_SRC-1:0] ovf_evt;
    logic [NUM_SRC-1:0] slot_wr;
    logic [NUM_SRC-1:0] drain;

    // Arbitration
    logic             win_found;
    logic [SRC_W-1:0] win_idx;
    logic [SRC_W:0]   cand;
    logic             load_en;

    logic [SUM_W-1:0] sup_sum;
    logic [SUM_W-1:0] ovf_sum;

`ifdef ASSERT_RPT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;
    logic [TS_W-1:0] slot_ts_q [NUM_SRC];
    logic [TS_W-1:0] rpt_time_q;

    // Free-running cycle counter; deliberately untouched by clr_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts_q <= '0;
        else        ts_q <= ts_q + TS_W'(1);
    end

    assign rpt_time_o = rpt_time_q;
`endif

    // Round-robin search: first full slot at or above ptr, wrapping around
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = {1'b0, ptr_q} + (SRC_W+1)'(i);
            if (cand >= (SRC_W+1)'(NUM_SRC)) cand = cand - (SRC_W+1)'(NUM_SRC);
            if (!win_found && slot_full_q[cand[SRC_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[SRC_W-1:0];
            end
        end
    end

    // A new report is loaded when the output register is free or being
    // accepted this edge; a clear empties the slots so nothing is loaded then
    assign load_en = !clr_i && win_found && (state_q == ST_IDLE || rpt_ready_i);

    assign ptr_d = (win_idx == SRC_W'(NUM_SRC - 1)) ? '0 : win_idx + SRC_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign accept[gi]  = fail_i[gi] && src_en_i[gi] && !clr_i;
            assign to_slot[gi] = accept[gi] && (fail_cnt_q[gi] < MAX_RPT);
            assign sup_evt[gi] = accept[gi] && !(fail_cnt_q[gi] < MAX_RPT);
            assign drain[gi]   = load_en && (win_idx == SRC_W'(gi));
            // A slot being drained at this edge can take the new event
            assign ovf_evt[gi] = to_slot[gi] && slot_full_q[gi] && !drain[gi];
            assign slot_wr[gi] = to_slot[gi] && !ovf_evt[gi];

            assign fail_cnt_o[gi*CNT_W +: CNT_W] = fail_cnt_q[gi];

            // Per-source failure count and single-entry pending slot
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    fail_cnt_q[gi]  <= '0;
                    slot_full_q[gi] <= 1'b0;
                    slot_id_q[gi]   <= '0;
                    slot_seq_q[gi]  <= '0;
`ifdef ASSERT_RPT_TIMESTAMP_EN
                    slot_ts_q[gi]   <= '0;
`endif
                end else if (clr_i) begin
                    fail_cnt_q[gi]  <= '0;
                    slot_full_q[gi] <= 1'b0;
                end else begin
                    if (accept[gi] && fail_cnt_q[gi] != CNT_MAX)
                        fail_cnt_q[gi] <= fail_cnt_q[gi] + CNT_W'(1);
                    if (slot_wr[gi]) begin
                        slot_full_q[gi] <= 1'b1;
                        slot_id_q[gi]   <= fail_id_i[gi*ID_W +: ID_W];
                        slot_seq_q[gi]  <= fail_cnt_q[gi] + CNT_W'(1);
`ifdef ASSERT_RPT_TIMESTAMP_EN
                        slot_ts_q[gi]   <= ts_q;
`endif
                    end else if (drain[gi]) begin
                        slot_full_q[gi] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    // Saturating totals for suppressed and overflowed events across sources
    always_comb begin
        sup_sum = {{(SUM_W-CNT_W){1'b0}}, sup_cnt_q};
        ovf_sum = {{(SUM_W-CNT_W){1'b0}}, ovf_cnt_q};
        for (int i = 0; i < NUM_SRC; i++) begin
            sup_sum = sup_sum + SUM_W'(sup_evt[i]);
            ovf_sum = ovf_sum + SUM_W'(ovf_evt[i]);
        end
        sup_cnt_d  = (sup_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sup_sum[CNT_W-1:0];
        ovf_cnt_d  = (ovf_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : ovf_sum[CNT_W-1:0];
        any_fail_d = any_fail_q || (|accept);
        if (clr_i) begin
            sup_cnt_d  = '0;
            ovf_cnt_d  = '0;
            any_fail_d = 1'b0;
        end
    end

    // Global counter and sticky-flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sup_cnt_q  <= '0;
            ovf_cnt_q  <= '0;
            any_fail_q <= 1'b0;
        end else begin
            sup_cnt_q  <= sup_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            any_fail_q <= any_fail_d;
        end
    end

    // Report FSM: loads RR winners into the output register, holds on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            valid_q    <= 1'b0;
            rpt_src_q  <= '0;
            rpt_id_q   <= '0;
            rpt_seq_q  <= '0;
            ptr_q      <= '0;
`ifdef ASSERT_RPT_TIMESTAMP_EN
            rpt_time_q <= '0;
`endif
        end else begin
            if (load_en) begin
                state_q    <= ST_PRESENT;
                valid_q    <= 1'b1;
                rpt_src_q  <= win_idx;
                rpt_id_q   <= slot_id_q[win_idx];
                rpt_seq_q  <= slot_seq_q[win_idx];
`ifdef ASSERT_RPT_TIMESTAMP_EN
                rpt_time_q <= slot_ts_q[win_idx];
`endif
            end else if (state_q == ST_PRESENT && rpt_ready_i) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
            end
            if (clr_i)        ptr_q <= '0;
            else if (load_en) ptr_q <= ptr_d;
        end
    end

    assign rpt_valid_o = valid_q;
    assign rpt_src_o   = rpt_src_q;
    assign rpt_id_o    = rpt_id_q;
    assign rpt_seq_o   = rpt_seq_q;
    assign sup_cnt_o   = sup_cnt_q;
    assign ovf_cnt_o   = ovf_cnt_q;
    assign any_fail_o  = any_fail_q;

endmodule
